updown_counter_mod: RTL

- Parametrised successor to the basic up/down counter.
- Adds the following: up/down direction select, programmable step, programmable modulus (max_val), wrap or saturate mode, synchronous load, clock prescaler, terminal-count pulse and sticky overflow flag.
- Serves as the general-purpose event/timebase counter for lab designs, e.g. display refresh, PWM period and LFSR seeding.

---
 rtl/counter_pkg.sv | 11 +
 rtl/counter_prescaler.sv | 31 +++
 rtl/updown_counter_mod.sv | 84 ++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared enums and default widths for the up/down counter
package counter_pkg;

  typedef enum logic {DIR_DOWN = 1'b0, DIR_UP = 1'b1} dir_e;
  typedef enum logic {MODE_WRAP = 1'b0, MODE_SAT = 1'b1} mode_e;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_STEP_W = 4;
  localparam int DEF_PRE_W  = 4;

endpackage

// File: rtl/counter_prescaler.sv
// rtl/counter_prescaler.sv - enable-gated divide-by-(div+1) advance strobe
module counter_prescaler
  import counter_pkg::*;
#(
  parameter int PRE_W = DEF_PRE_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [PRE_W-1:0] div,
  output logic             adv
);

  logic [PRE_W-1:0] pcnt;
  logic             match;

  // >= rather than == so a div lowered below pcnt still terminates the period
  assign match = (pcnt >= div);
  assign adv   = en && match;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      pcnt <= '0;
    end else if (en) begin
      if (match) pcnt <= '0;
      else       pcnt <= pcnt + 1'b1;
    end
  end

endmodule

// File: rtl/updown_counter_mod.sv
// rtl/updown_counter_mod.sv - up/down counter with step, modulus, wrap/saturate, load and prescaler
module updown_counter_mod
  import counter_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STEP_W = DEF_STEP_W,
  parameter int PRE_W  = DEF_PRE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              up,
  input  logic [STEP_W-1:0] step,
  input  logic [PRE_W-1:0]  div,
  input  logic              sat_mode,
  input  logic [WIDTH-1:0]  max_val,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  output logic [WIDTH-1:0]  count,
  output logic              tc,
  output logic              ovf
);

  logic             adv;
  logic [WIDTH:0]   cnt_ext, step_ext, max_ext, raw;
  logic             above, out_of_range;
  logic [WIDTH-1:0] adv_count, load_clamped;

  counter_prescaler #(.PRE_W(PRE_W)) u_prescaler (
    .clk (clk),
    .rst (rst),
    .clr (load),
    .en  (en),
    .div (div),
    .adv (adv)
  );

  // One extra bit so overflow past max_val and borrow below zero are both visible
  assign cnt_ext  = {1'b0, count};
  assign step_ext = (WIDTH+1)'(step);
  assign max_ext  = {1'b0, max_val};
  assign above    = (count > max_val);

  assign load_clamped = (load_val > max_val) ? max_val : load_val;

  always_comb begin
    raw          = '0;
    out_of_range = 1'b0;
    adv_count    = count;
    if (dir_e'(up) == DIR_UP) begin
      raw          = cnt_ext + step_ext;
      out_of_range = (raw > max_ext) || above;
    end else begin
      raw          = cnt_ext - step_ext;
      out_of_range = (cnt_ext < step_ext) || above;
    end
    if (!out_of_range) begin
      adv_count = raw[WIDTH-1:0];
    end else if ((mode_e'(sat_mode) == MODE_SAT) == (dir_e'(up) == DIR_UP)) begin
      adv_count = max_val;
    end else begin
      adv_count = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      tc    <= 1'b0;
      ovf   <= 1'b0;
    end else if (load) begin
      count <= load_clamped;
      tc    <= 1'b0;
      ovf   <= 1'b0;
    end else if (adv) begin
      count <= adv_count;
      tc    <= out_of_range;
      if (out_of_range) ovf <= 1'b1;
    end else begin
      tc <= 1'b0;
    end
  end

endmodule
